// File: rtl/uart_fifo_mem.sv
// Dual-port UART register bank with parametrised TX/RX FIFOs, sticky overflow, flush and level irq.
// Latency: reads are combinational; FIFO, status, tx_pending and irq update on the next posedge.
// Backpressure: none; a push to a full FIFO is dropped and sets its sticky overflow flag.
// Optional: define UART_TIMESTAMP_EN to add a 16-bit cycle counter captured on RX push (CPU 0x28).
module uart_fifo_mem #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] addr_cpu,
    input  logic        rd_en_cpu,
    input  logic        wr_en_cpu,
    input  logic [31:0] wdata_cpu,
    output logic [31:0] rdata_cpu,
    output logic        tx_pending,
    output logic        irq
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [7:0] A_TXDATA = 8'h18;
    localparam logic [7:0] A_RXDATA = 8'h1c;
    localparam logic [7:0] A_STATUS = 8'h20;
    localparam logic [7:0] A_CTRL   = 8'h24;
    localparam logic [7:0] A_TS     = 8'h28;

    logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
    logic [TX_AW-1:0]  r_tx_wptr, r_tx_rptr;
    logic [RX_AW-1:0]  r_rx_wptr, r_rx_rptr;
    logic [TX_CW-1:0]  r_tx_cnt;
    logic [RX_CW-1:0]  r_rx_cnt;
    logic              r_state, r_tx_ovf, r_rx_ovf;
    logic              r_rx_irq_en, r_tx_irq_en;
    logic              r_tx_pending, r_irq;

    // Address decode: TX is filled by the CPU and drained by the peripheral, RX the reverse.
    wire w_cpu_wr_tx   = wr_en_cpu && (addr_cpu[7:0] == A_TXDATA);
    wire w_cpu_rd_rx   = rd_en_cpu && (addr_cpu[7:0] == A_RXDATA);
    wire w_cpu_wr_stat = wr_en_cpu && (addr_cpu[7:0] == A_STATUS);
    wire w_cpu_wr_ctrl = wr_en_cpu && (addr_cpu[7:0] == A_CTRL);
    wire w_per_rd_tx   = rd_en && (addr[7:0] == A_TXDATA);
    wire w_per_wr_rx   = wr_en && (addr[7:0] == A_RXDATA);

    wire w_clr_ovf  = w_cpu_wr_ctrl && wdata_cpu[2];
    wire w_flush_tx = w_cpu_wr_ctrl && wdata_cpu[3];
    wire w_flush_rx = w_cpu_wr_ctrl && wdata_cpu[4];

    wire w_tx_full  = (r_tx_cnt == TX_CW'(TX_DEPTH));
    wire w_tx_empty = (r_tx_cnt == '0);
    wire w_rx_full  = (r_rx_cnt == RX_CW'(RX_DEPTH));
    wire w_rx_empty = (r_rx_cnt == '0);

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside a pop.
    wire w_tx_pop     = w_per_rd_tx && !w_tx_empty;
    wire w_tx_push    = w_cpu_wr_tx && (!w_tx_full || w_tx_pop);
    wire w_tx_ovf_set = w_cpu_wr_tx && w_tx_full && !w_tx_pop && !w_flush_tx;
    wire w_rx_pop     = w_cpu_rd_rx && !w_rx_empty;
    wire w_rx_push    = w_per_wr_rx && (!w_rx_full || w_rx_pop);
    wire w_rx_ovf_set = w_per_wr_rx && w_rx_full && !w_rx_pop && !w_flush_rx;

    // Enables as they will be after this edge, so irq tracks post-edge state.
    wire w_rx_irq_en_nxt = w_cpu_wr_ctrl ? wdata_cpu[0] : r_rx_irq_en;
    wire w_tx_irq_en_nxt = w_cpu_wr_ctrl ? wdata_cpu[1] : r_tx_irq_en;

    // Bus bits outside the decoded/character range are intentionally ignored.
    wire w_unused_bits = ^{addr, addr_cpu, wdata, wdata_cpu};

    logic [TX_CW-1:0] w_tx_cnt_nxt;
    logic [RX_CW-1:0] w_rx_cnt_nxt;

    // Next occupancy: flush overrides, otherwise net of accepted push and pop.
    always_comb begin
        w_tx_cnt_nxt = r_tx_cnt;
        w_rx_cnt_nxt = r_rx_cnt;
        if (w_flush_tx)
            w_tx_cnt_nxt = '0;
        else if (w_tx_push && !w_tx_pop)
            w_tx_cnt_nxt = r_tx_cnt + TX_CW'(1);
        else if (w_tx_pop && !w_tx_push)
            w_tx_cnt_nxt = r_tx_cnt - TX_CW'(1);
        if (w_flush_rx)
            w_rx_cnt_nxt = '0;
        else if (w_rx_push && !w_rx_pop)
            w_rx_cnt_nxt = r_rx_cnt + RX_CW'(1);
        else if (w_rx_pop && !w_rx_push)
            w_rx_cnt_nxt = r_rx_cnt - RX_CW'(1);
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wptr] <= wdata_cpu[DATA_W-1:0];
        if (w_rx_push)
            r_rx_mem[r_rx_wptr] <= wdata[DATA_W-1:0];
    end

    // Pointers and counts; pointers wrap naturally because depths are powers of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            r_tx_cnt <= w_tx_cnt_nxt;
            r_rx_cnt <= w_rx_cnt_nxt;
            if (w_flush_tx) begin
                r_tx_wptr <= '0;
                r_tx_rptr <= '0;
            end else begin
                if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_AW'(1);
                if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_AW'(1);
            end
            if (w_flush_rx) begin
                r_rx_wptr <= '0;
                r_rx_rptr <= '0;
            end else begin
                if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_AW'(1);
                if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_AW'(1);
            end
        end
    end

    // Control, state bit and sticky overflow flags; an overflow set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_rx_irq_en <= 1'b0;
            r_tx_irq_en <= 1'b0;
        end else begin
            if (w_cpu_wr_stat)
                r_state <= wdata_cpu[4];
            r_rx_irq_en <= w_rx_irq_en_nxt;
            r_tx_irq_en <= w_tx_irq_en_nxt;
            if (w_tx_ovf_set)   r_tx_ovf <= 1'b1;
            else if (w_clr_ovf) r_tx_ovf <= 1'b0;
            if (w_rx_ovf_set)   r_rx_ovf <= 1'b1;
            else if (w_clr_ovf) r_rx_ovf <= 1'b0;
        end
    end

    // Registered outputs computed from post-edge occupancy and enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_pending <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_tx_pending <= (w_tx_cnt_nxt != '0);
            r_irq        <= (w_rx_irq_en_nxt && (w_rx_cnt_nxt != '0)) ||
                            (w_tx_irq_en_nxt && (w_tx_cnt_nxt == '0));
        end
    end

    assign tx_pending = r_tx_pending;
    assign irq        = r_irq;

    wire [31:0] w_tx_head = w_tx_empty ? 32'h0 : 32'(r_tx_mem[r_tx_rptr]);
    wire [31:0] w_rx_head = w_rx_empty ? 32'h0 : 32'(r_rx_mem[r_rx_rptr]);
    wire [31:0] w_status  = {8'h0, 8'(r_rx_cnt), 8'(r_tx_cnt), 1'b0, r_rx_ovf, r_tx_ovf,
                             r_state, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
    wire [31:0] w_ctrl    = {30'h0, r_tx_irq_en, r_rx_irq_en};
    wire [31:0] w_ts_rd;

`ifdef UART_TIMESTAMP_EN
    logic [15:0] r_ts_cnt, r_ts;

    // Free-running cycle counter, sampled whenever an RX byte is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts_cnt <= 16'h0;
            r_ts     <= 16'h0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 16'h1;
            if (w_rx_push)
                r_ts <= r_ts_cnt;
        end
    end

    assign w_ts_rd = {16'h0, r_ts};
`else
    assign w_ts_rd = 32'h0;
`endif

    // Peripheral read mux: drains TX, sees status and control.
    always_comb begin
        rdata = 32'h0;
        if (rd_en) begin
            case (addr[7:0])
                A_TXDATA: rdata = w_tx_head;
                A_STATUS: rdata = w_status;
                A_CTRL:   rdata = w_ctrl;
                default:  rdata = 32'h0;
            endcase
        end
    end

    // CPU read mux: drains RX, sees status, control and the optional timestamp.
    always_comb begin
        rdata_cpu = 32'h0;
        if (rd_en_cpu) begin
            case (addr_cpu[7:0])
                A_RXDATA: rdata_cpu = w_rx_head;
                A_STATUS: rdata_cpu = w_status;
                A_CTRL:   rdata_cpu = w_ctrl;
                A_TS:     rdata_cpu = w_ts_rd;
                default:  rdata_cpu = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_mem.sv
module tb_uart_fifo_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] addr_cpu = '0;
    logic        rd_en_cpu = 1'b0;
    logic        wr_en_cpu = 1'b0;
    logic [31:0] wdata_cpu = '0;
    logic [31:0] rdata_cpu;
    logic        tx_pending;
    logic        irq;
    logic        chk_flg = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_cpu_exp[$];
    string       q_cpu_nm[$];
    logic [31:0] q_per_exp[$];
    string       q_per_nm[$];
    logic [1:0]  q_flg_exp[$];
    string       q_flg_nm[$];

    uart_fifo_mem dut (
        .clk(clk), .reset(reset),
        .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wdata(wdata), .rdata(rdata),
        .addr_cpu(addr_cpu), .rd_en_cpu(rd_en_cpu), .wr_en_cpu(wr_en_cpu),
        .wdata_cpu(wdata_cpu), .rdata_cpu(rdata_cpu),
        .tx_pending(tx_pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations, away from the active edge.
    always @(negedge clk) begin
        if (rd_en_cpu) begin
            if (q_cpu_exp.size() == 0) check("cpu_unexpected_read", 32'h1, 32'h0);
            else check(q_cpu_nm.pop_front(), rdata_cpu, q_cpu_exp.pop_front());
        end
        if (rd_en) begin
            if (q_per_exp.size() == 0) check("per_unexpected_read", 32'h1, 32'h0);
            else check(q_per_nm.pop_front(), rdata, q_per_exp.pop_front());
        end
        if (chk_flg) begin
            if (q_flg_exp.size() == 0) check("flag_unexpected", 32'h1, 32'h0);
            else check(q_flg_nm.pop_front(), {30'h0, irq, tx_pending}, {30'h0, q_flg_exp.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cpu(input logic [31:0] e, input string nm);
        q_cpu_exp.push_back(e);
        q_cpu_nm.push_back(nm);
    endtask

    task automatic exp_per(input logic [31:0] e, input string nm);
        q_per_exp.push_back(e);
        q_per_nm.push_back(nm);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
        addr_cpu = {24'h0, a}; wdata_cpu = d; wr_en_cpu = 1'b1;
        tick();
        wr_en_cpu = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        exp_cpu(e, nm);
        addr_cpu = {24'h0, a}; rd_en_cpu = 1'b1;
        tick();
        rd_en_cpu = 1'b0;
    endtask

    task automatic per_wr(input logic [7:0] a, input logic [31:0] d);
        addr = {24'h0, a}; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic per_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        exp_per(e, nm);
        addr = {24'h0, a}; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Expected {irq, tx_pending} as seen after the most recent edge.
    task automatic flags(input logic e_irq, input logic e_txp, input string nm);
        q_flg_exp.push_back({e_irq, e_txp});
        q_flg_nm.push_back(nm);
        chk_flg = 1'b1;
        tick();
        chk_flg = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        cpu_rd(8'h20, 32'h0000_000A, "rst_status_cpu");
        per_rd(8'h20, 32'h0000_000A, "rst_status_per");
        cpu_rd(8'h24, 32'h0, "rst_ctrl");
        flags(1'b0, 1'b0, "rst_flags");

        // TX path: push three, drain three in order
        cpu_wr(8'h18, 32'h41);
        cpu_wr(8'h18, 32'h42);
        cpu_wr(8'h18, 32'hFFFF_FF43);
        cpu_rd(8'h20, 32'h0000_0308, "tx3_status");
        flags(1'b0, 1'b1, "tx3_pending");
        per_rd(8'h18, 32'h41, "tx_pop0");
        per_rd(8'h18, 32'h42, "tx_pop1");
        per_rd(8'h18, 32'h43, "tx_pop2");
        flags(1'b0, 1'b0, "tx_drained_flags");
        cpu_rd(8'h20, 32'h0000_000A, "tx_drained_status");
        per_rd(8'h18, 32'h0, "tx_pop_empty");

        // RX overflow: 17 pushes into depth 16
        for (int i = 0; i <= 16; i++) per_wr(8'h1c, 32'(i));
        cpu_rd(8'h20, 32'h0010_0046, "rx_ovf_status");
        for (int i = 0; i < 16; i++) cpu_rd(8'h1c, 32'(i), "rx_drain");
        cpu_rd(8'h20, 32'h0000_004A, "rx_ovf_sticky");
        cpu_wr(8'h24, 32'h4);
        cpu_rd(8'h20, 32'h0000_000A, "rx_ovf_cleared");

        // Wrong-side writes and the state bit
        cpu_wr(8'h20, 32'h10);
        cpu_rd(8'h20, 32'h0000_001A, "state_set");
        per_wr(8'h20, 32'h0);
        per_rd(8'h20, 32'h0000_001A, "state_per_wr_ignored");
        cpu_wr(8'h20, 32'h0);
        per_wr(8'h24, 32'h3);
        cpu_rd(8'h24, 32'h0, "ctrl_per_wr_ignored");
        per_wr(8'h18, 32'h77);
        cpu_wr(8'h1c, 32'h77);
        cpu_rd(8'h20, 32'h0000_000A, "wrong_side_push_ignored");

        // RX irq
        cpu_wr(8'h24, 32'h1);
        cpu_rd(8'h24, 32'h1, "ctrl_readback");
        flags(1'b0, 1'b0, "irq_rx_idle");
        per_wr(8'h1c, 32'h55);
        flags(1'b1, 1'b0, "irq_rx_set");
        cpu_rd(8'h1c, 32'h55, "rx_55");
        flags(1'b0, 1'b0, "irq_rx_clr");

        // TX irq on empty
        cpu_wr(8'h24, 32'h2);
        flags(1'b1, 1'b0, "irq_tx_empty");
        cpu_wr(8'h18, 32'h99);
        flags(1'b0, 1'b1, "irq_tx_busy");
        per_rd(8'h18, 32'h99, "tx_99");
        flags(1'b1, 1'b0, "irq_tx_empty_again");
        cpu_wr(8'h24, 32'h0);
        flags(1'b0, 1'b0, "irq_disabled");

        // Simultaneous push/pop on RX: one entry, then empty
        per_wr(8'h1c, 32'hA1);
        exp_cpu(32'hA1, "rx_pushpop_head");
        addr = 32'h1c; wdata = 32'hA2; wr_en = 1'b1;
        addr_cpu = 32'h1c; rd_en_cpu = 1'b1;
        tick();
        wr_en = 1'b0; rd_en_cpu = 1'b0;
        cpu_rd(8'h20, 32'h0001_0002, "rx_pushpop_cnt1");
        cpu_rd(8'h1c, 32'hA2, "rx_A2");
        exp_cpu(32'h0, "rx_pushpop_empty_read");
        addr = 32'h1c; wdata = 32'hA3; wr_en = 1'b1;
        addr_cpu = 32'h1c; rd_en_cpu = 1'b1;
        tick();
        wr_en = 1'b0; rd_en_cpu = 1'b0;
        cpu_rd(8'h20, 32'h0001_0002, "rx_pushpop_empty_cnt");
        cpu_rd(8'h1c, 32'hA3, "rx_A3");

        // Simultaneous push/pop on a full RX FIFO: no overflow, order kept across wrap
        for (int i = 0; i < 16; i++) per_wr(8'h1c, 32'h30 + 32'(i));
        exp_cpu(32'h30, "rx_full_pushpop_head");
        addr = 32'h1c; wdata = 32'h50; wr_en = 1'b1;
        addr_cpu = 32'h1c; rd_en_cpu = 1'b1;
        tick();
        wr_en = 1'b0; rd_en_cpu = 1'b0;
        cpu_rd(8'h20, 32'h0010_0006, "rx_full_pushpop_status");
        for (int i = 1; i < 16; i++) cpu_rd(8'h1c, 32'h30 + 32'(i), "rx_wrap_drain");
        cpu_rd(8'h1c, 32'h50, "rx_wrap_last");
        cpu_rd(8'h20, 32'h0000_000A, "rx_wrap_empty");

        // TX flush together with a peripheral pop
        for (int i = 0; i < 5; i++) cpu_wr(8'h18, 32'h61 + 32'(i));
        cpu_rd(8'h20, 32'h0000_0508, "tx5_status");
        flags(1'b0, 1'b1, "tx5_flags");
        exp_per(32'h61, "tx_flush_pop_head");
        addr_cpu = 32'h24; wdata_cpu = 32'h8; wr_en_cpu = 1'b1;
        addr = 32'h18; rd_en = 1'b1;
        tick();
        wr_en_cpu = 1'b0; rd_en = 1'b0;
        cpu_rd(8'h20, 32'h0000_000A, "tx_flushed_status");
        flags(1'b0, 1'b0, "tx_flushed_flags");

        // RX flush keeps a sticky overflow
        for (int i = 0; i <= 16; i++) per_wr(8'h1c, 32'hC0 + 32'(i));
        cpu_wr(8'h24, 32'h10);
        cpu_rd(8'h20, 32'h0000_004A, "rx_flush_keeps_ovf");
        cpu_wr(8'h24, 32'h4);
        cpu_rd(8'h20, 32'h0000_000A, "rx_flush_ovf_cleared");

        // Reset mid-fill
        for (int i = 0; i < 3; i++) cpu_wr(8'h18, 32'h80 + 32'(i));
        per_wr(8'h1c, 32'h11);
        per_wr(8'h1c, 32'h12);
        cpu_wr(8'h20, 32'h10);
        cpu_wr(8'h24, 32'h3);
        flags(1'b1, 1'b1, "pre_reset_flags");
        reset = 1'b1;
        addr_cpu = 32'h18; wdata_cpu = 32'h90; wr_en_cpu = 1'b1;
        tick();
        reset = 1'b0; wr_en_cpu = 1'b0;
        cpu_rd(8'h20, 32'h0000_000A, "post_reset_status");
        cpu_rd(8'h24, 32'h0, "post_reset_ctrl");
        flags(1'b0, 1'b0, "post_reset_flags");
        per_rd(8'h18, 32'h0, "post_reset_tx_empty");
        cpu_rd(8'h1c, 32'h0, "post_reset_rx_empty");

        // Unmapped addresses
        cpu_rd(8'h30, 32'h0, "cpu_unmapped");
        per_rd(8'h34, 32'h0, "per_unmapped");
`ifndef UART_TIMESTAMP_EN
        cpu_rd(8'h28, 32'h0, "ts_absent");
`endif

        tick();
        tick();
        check("cpu_queue_drained", 32'(q_cpu_exp.size()), 32'h0);
        check("per_queue_drained", 32'(q_per_exp.size()), 32'h0);
        check("flag_queue_drained", 32'(q_flg_exp.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
